vect_alu_arbiter: RTL and testbench

//   Shares the single vector ALU (MULI/SLRI/SLLI/SARI lanes) between two requesters: port 0 is the

---
 rtl/vect_alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_vect_alu_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vect_alu_arbiter.sv
// Round-robin arbiter sharing one combinational vector ALU between the instruction pipeline (port 0)
// and the FIR tap engine (port 1). One transaction in flight: IDLE -> EXEC -> RESP -> IDLE.
module vect_alu_arbiter_lane #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap_i,
  input  logic         legal_i,
  input  logic [N-1:0] res_i,
  output logic [N-1:0] q_o
);
  logic [N-1:0] q_q;

  always_ff @(posedge clk or posedge rst)
    if (rst)        q_q <= '0;
    else if (cap_i) q_q <= legal_i ? res_i : '0;

  assign q_o = q_q;
endmodule

module vect_alu_arbiter #(
  parameter int N = 8,
  parameter int M = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [3:0]     req0_ctrl,
  input  logic [M*N-1:0] req0_a,
  input  logic [M*N-1:0] req0_b,
  input  logic [3:0]     req1_ctrl,
  input  logic [M*N-1:0] req1_a,
  input  logic [M*N-1:0] req1_b,
  output logic [3:0]     alu_ctrl,
  output logic [M*N-1:0] alu_a,
  output logic [M*N-1:0] alu_b,
  input  logic [M*N-1:0] alu_result,
  input  logic [3:0]     alu_flags,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [M*N-1:0] rsp_data,
  output logic [3:0]     rsp_flags,
  output logic           rsp_err,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic           last_q, gnt_q;
  logic [3:0]     ctrl_q, flags_q;
  logic [M*N-1:0] a_q, b_q;
  logic           err_q;
  logic           any_req, gnt, accept, done, legal, cap;
  logic [M-1:0][N-1:0] rsp_lanes;

  // On a tie the requester that did not win last time goes next.
  assign any_req = |req_valid;
  always_comb begin
    gnt = 1'b0;
    case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_q;
      default: gnt = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && any_req;
  assign done   = (state_q == RESP) && rsp_ready[gnt_q];
  assign legal  = (ctrl_q[3:2] == 2'b10);
  assign cap    = (state_q == EXEC);

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (accept)            req_ready[gnt]   = 1'b1;
    if (state_q == RESP)   rsp_valid[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_q <= 1'b1;
      gnt_q  <= 1'b0;
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      if (accept) begin
        gnt_q  <= gnt;
        ctrl_q <= gnt ? req1_ctrl : req0_ctrl;
        a_q    <= gnt ? req1_a    : req0_a;
        b_q    <= gnt ? req1_b    : req0_b;
      end
      if (done) last_q <= gnt_q;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else if (cap) begin
      flags_q <= legal ? alu_flags : 4'h0;
      err_q   <= ~legal;
    end

  // Lane i sits at bits [(M-1-i)*N +: N], i.e. packed element M-1-i.
  for (genvar i = 0; i < M; i++) begin : g_lane
    vect_alu_arbiter_lane #(.N(N)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .cap_i   (cap),
      .legal_i (legal),
      .res_i   (alu_result[(M-1-i)*N +: N]),
      .q_o     (rsp_lanes[M-1-i])
    );
  end

  assign rsp_data  = rsp_lanes;
  assign rsp_flags = flags_q;
  assign rsp_err   = err_q;
  assign alu_ctrl  = ctrl_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_vect_alu_arbiter.sv
// Directed bench for vect_alu_arbiter with a small behavioural vector ALU attached.
module tb_vect_alu_arbiter;
  localparam int N = 8;
  localparam int M = 16;
  localparam int W = M*N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = '0, req_ready;
  logic [3:0]   req0_ctrl = '0, req1_ctrl = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]   alu_ctrl, alu_flags;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [1:0]   rsp_valid, rsp_ready = '0;
  logic [W-1:0] rsp_data;
  logic [3:0]   rsp_flags;
  logic         rsp_err, busy;
  int           checks = 0, errors = 0;

  always #5 clk = ~clk;

  vect_alu_arbiter #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
    .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [W-1:0] alu_f(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [7:0]   x, y, p;
    r = '0;
    for (int i = 0; i < M; i++) begin
      x = a[i*N +: N];
      y = b[i*N +: N];
      p = 8'h00;
      case (c)
        4'b1000: p = x * y;
        4'b1001: p = x >> y[2:0];
        4'b1010: p = x << y[2:0];
        4'b1011: p = $unsigned($signed(x) >>> y[2:0]);
        default: p = 8'h00;
      endcase
      r[i*N +: N] = p;
    end
    return r;
  endfunction

  assign alu_result = alu_f(alu_ctrl, alu_a, alu_b);
  assign alu_flags  = {alu_result[W-1], alu_result == '0, alu_ctrl[0], alu_ctrl[1]};

  function automatic logic [W-1:0] rep(input logic [7:0] v);
    return {M{v}};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    // reset state
    #12;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_rspv", W'(rsp_valid), W'(0));
    chk("rst_reqr", W'(req_ready), W'(0));
    chk("rst_alua", alu_a, '0);
    chk("rst_err",  W'(rsp_err), W'(0));
    @(negedge clk); rst = 1'b0;
    tick();

    // 1: single MULI from port 0
    req0_ctrl = 4'b1000; req0_a = rep(8'h03); req0_b = rep(8'h05);
    rsp_ready = 2'b11; req_valid = 2'b01; #1;
    chk("t1_reqr", W'(req_ready), W'(2'b01));
    tick(); req_valid = 2'b00; #1;
    chk("t1_busy_exec", W'(busy), W'(1));
    chk("t1_reqr_exec", W'(req_ready), W'(0));
    chk("t1_rspv_exec", W'(rsp_valid), W'(0));
    chk("t1_aluctrl", W'(alu_ctrl), W'(4'b1000));
    chk("t1_alua", alu_a, rep(8'h03));
    tick();
    chk("t1_rspv", W'(rsp_valid), W'(2'b01));
    chk("t1_data", rsp_data, rep(8'h0F));
    chk("t1_err", W'(rsp_err), W'(0));
    chk("t1_flags", W'(rsp_flags), W'(4'b0000));
    tick();
    chk("t1_busy_fall", W'(busy), W'(0));
    chk("t1_alua_held", alu_a, rep(8'h03));

    // 2: both valid from reset, strict alternation starting with port 0
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    req0_ctrl = 4'b1010; req0_a = rep(8'h01); req0_b = rep(8'h03);
    req1_ctrl = 4'b1010; req1_a = rep(8'h01); req1_b = rep(8'h03);
    req_valid = 2'b11; rsp_ready = 2'b11; #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("t2_grant%0d", k), W'(req_ready), W'(exp_g));
      tick(); tick();
      chk($sformatf("t2_rspv%0d", k), W'(rsp_valid), W'(exp_g));
      chk($sformatf("t2_data%0d", k), rsp_data, rep(8'h08));
      chk($sformatf("t2_flags%0d", k), W'(rsp_flags), W'(4'b0001));
      tick();
    end
    req_valid = 2'b00;
    tick();

    // 3: port 1 SLLI stalled on rsp_ready[1]; port 0 waits with an illegal op
    req1_ctrl = 4'b1010; req1_a = rep(8'h02); req1_b = rep(8'h01);
    req0_ctrl = 4'b0011; req0_a = rep(8'h11); req0_b = rep(8'h22);
    rsp_ready = 2'b01; req_valid = 2'b10; #1;
    chk("t3_reqr", W'(req_ready), W'(2'b10));
    tick(); req_valid = 2'b01; tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_rspv%0d", k), W'(rsp_valid), W'(2'b10));
      chk($sformatf("t3_data%0d", k), rsp_data, rep(8'h04));
      chk($sformatf("t3_reqr%0d", k), W'(req_ready), W'(0));
      tick();
    end
    rsp_ready = 2'b10; #1;
    chk("t3_last_rspv", W'(rsp_valid), W'(2'b10));
    chk("t3_last_flags", W'(rsp_flags), W'(4'b0001));
    tick();

    // 4: waiting illegal op from port 0 now granted
    chk("t4_reqr", W'(req_ready), W'(2'b01));
    tick(); req_valid = 2'b00; rsp_ready = 2'b11; tick();
    chk("t4_rspv", W'(rsp_valid), W'(2'b01));
    chk("t4_data", rsp_data, '0);
    chk("t4_flags", W'(rsp_flags), W'(0));
    chk("t4_err", W'(rsp_err), W'(1));
    tick();
    req0_ctrl = 4'b1001; req0_a = rep(8'h80); req0_b = rep(8'h03); req_valid = 2'b01;
    tick(); req_valid = 2'b00; tick();
    chk("t4_legal_err", W'(rsp_err), W'(0));
    chk("t4_srl_data", rsp_data, rep(8'h10));
    tick();

    // 5: reset during EXEC of a port 1 op
    req1_ctrl = 4'b1011; req1_a = rep(8'h80); req1_b = rep(8'h01); req_valid = 2'b10;
    tick(); req_valid = 2'b00;
    chk("t5_busy_exec", W'(busy), W'(1));
    rst = 1'b1; #1;
    chk("t5_busy_rst", W'(busy), W'(0));
    chk("t5_rspv_rst", W'(rsp_valid), W'(0));
    tick();
    chk("t5_rspv_hold", W'(rsp_valid), W'(0));
    @(negedge clk); rst = 1'b0;
    req0_ctrl = 4'b1000; req0_a = rep(8'h02); req0_b = rep(8'h07);
    req_valid = 2'b11; #1;
    chk("t5_first_grant", W'(req_ready), W'(2'b01));
    tick(); req_valid = 2'b00; tick();
    chk("t5_rspv", W'(rsp_valid), W'(2'b01));
    chk("t5_data", rsp_data, rep(8'h0E));
    tick();

    // 6: port 1 request arrives while port 0 response is pending
    rsp_ready = 2'b00; req_valid = 2'b01;
    tick(); req_valid = 2'b00; tick();
    req1_ctrl = 4'b1011; req1_a = rep(8'h80); req1_b = rep(8'h02);
    req_valid = 2'b10; #1;
    chk("t6_reqr_resp", W'(req_ready), W'(0));
    tick();
    chk("t6_reqr_resp2", W'(req_ready), W'(0));
    rsp_ready = 2'b01; tick();
    chk("t6_reqr_idle", W'(req_ready), W'(2'b10));
    tick(); req_valid = 2'b00; tick();
    chk("t6_rspv", W'(rsp_valid), W'(2'b10));
    chk("t6_sar_data", rsp_data, rep(8'hE0));
    chk("t6_flags", W'(rsp_flags), W'(4'b1011));
    rsp_ready = 2'b10; tick();
    chk("t6_idle", W'(busy), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
